// File: rtl/frog_controller.sv
// Frog game-state stage: button hops with cooldown, level advance at the top row,
// freeze-then-respawn on car hits. Define LIVES_EN to add lives/game_over tracking.
module frog_controller #(
    parameter int unsigned STEP            = 32,
    parameter int unsigned START_X         = 304,
    parameter int unsigned START_Y         = 448,
    parameter int unsigned MAX_X           = 608,
    parameter int unsigned MAX_Y           = 448,
    parameter int unsigned MAX_LEVEL       = 8,
    parameter int unsigned COOLDOWN_FRAMES = 4,
    parameter int unsigned HIT_FRAMES      = 30,
    parameter int unsigned LIVES           = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       collision,
    output logic [9:0] frog_x,
    output logic [9:0] frog_y,
    output logic [3:0] current_level,
    output logic       level_up
`ifdef LIVES_EN
    ,
    output logic [1:0] lives,
    output logic       game_over
`endif
);

    localparam int unsigned CNT_MAX = (HIT_FRAMES > COOLDOWN_FRAMES) ? HIT_FRAMES
                                                                      : COOLDOWN_FRAMES;
    localparam int unsigned CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [10:0]      STEP_W    = 11'(STEP);
    localparam logic [10:0]      MAX_X_W   = 11'(MAX_X);
    localparam logic [10:0]      MAX_Y_W   = 11'(MAX_Y);
    localparam logic [9:0]       START_X_V = 10'(START_X);
    localparam logic [9:0]       START_Y_V = 10'(START_Y);
    localparam logic [3:0]       LEVEL_MAX = 4'(MAX_LEVEL);
    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_FRAMES);
    localparam logic [CNT_W-1:0] HIT_LOAD  = CNT_W'(HIT_FRAMES);
`ifdef LIVES_EN
    localparam logic [1:0]       LIVES_LOAD = 2'(LIVES);
`endif

    typedef enum logic [2:0] {
        StPlay,
        StCooldown,
        StLevelUp,
        StHit,
        StGameOver
    } state_e;

    state_e           state_q;
    logic [3:0]       btn_prev_q;
    logic [CNT_W-1:0] cnt_q;

    logic [3:0]  btn;
    logic [3:0]  press;
    logic        any_press;
    logic        hit_now;
    logic        cnt_done;
    logic [10:0] up_y, down_y, left_x, right_x;
    logic [9:0]  hop_x, hop_y;

    // Bit order gives the press priority: up > down > left > right.
    assign btn       = {btn_up, btn_down, btn_left, btn_right};
    assign press     = btn & ~btn_prev_q;
    assign any_press = |press;
    assign hit_now   = frame_tick & collision;
    assign cnt_done  = (cnt_q == '0) || (frame_tick && cnt_q == CNT_W'(1));

    always_comb begin
        up_y    = {1'b0, frog_y} - STEP_W;
        down_y  = {1'b0, frog_y} + STEP_W;
        left_x  = {1'b0, frog_x} - STEP_W;
        right_x = {1'b0, frog_x} + STEP_W;
        hop_x   = frog_x;
        hop_y   = frog_y;
        // Bit 10 set on a subtraction means it went negative.
        if (press[3]) begin
            hop_y = up_y[10] ? 10'd0 : up_y[9:0];
        end else if (press[2]) begin
            hop_y = (down_y > MAX_Y_W) ? MAX_Y_W[9:0] : down_y[9:0];
        end else if (press[1]) begin
            hop_x = left_x[10] ? 10'd0 : left_x[9:0];
        end else if (press[0]) begin
            hop_x = (right_x > MAX_X_W) ? MAX_X_W[9:0] : right_x[9:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StPlay;
            btn_prev_q    <= '0;
            cnt_q         <= '0;
            frog_x        <= START_X_V;
            frog_y        <= START_Y_V;
            current_level <= 4'd1;
            level_up      <= 1'b0;
`ifdef LIVES_EN
            lives         <= LIVES_LOAD;
            game_over     <= 1'b0;
`endif
        end else begin
            btn_prev_q <= btn;
            level_up   <= 1'b0;
            if (hit_now && (state_q == StPlay || state_q == StCooldown)) begin
`ifdef LIVES_EN
                if (lives == 2'd1) begin
                    lives         <= 2'd0;
                    game_over     <= 1'b1;
                    frog_x        <= START_X_V;
                    frog_y        <= START_Y_V;
                    current_level <= 4'd1;
                    cnt_q         <= '0;
                    state_q       <= StGameOver;
                end else begin
                    lives   <= lives - 2'd1;
                    cnt_q   <= HIT_LOAD;
                    state_q <= StHit;
                end
`else
                cnt_q   <= HIT_LOAD;
                state_q <= StHit;
`endif
            end else begin
                case (state_q)
                    StPlay: begin
                        if (any_press) begin
                            frog_x <= hop_x;
                            frog_y <= hop_y;
                            if (hop_y == 10'd0) begin
                                state_q <= StLevelUp;
                            end else begin
                                cnt_q   <= COOL_LOAD;
                                state_q <= StCooldown;
                            end
                        end
                    end
                    StCooldown: begin
                        if (cnt_done) begin
                            cnt_q   <= '0;
                            state_q <= StPlay;
                        end else if (frame_tick) begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    StLevelUp: begin
                        if (current_level < LEVEL_MAX) begin
                            current_level <= current_level + 4'd1;
                        end
                        level_up <= 1'b1;
                        frog_x   <= START_X_V;
                        frog_y   <= START_Y_V;
                        cnt_q    <= COOL_LOAD;
                        state_q  <= StCooldown;
                    end
                    StHit: begin
                        if (cnt_done) begin
                            frog_x  <= START_X_V;
                            frog_y  <= START_Y_V;
                            cnt_q   <= '0;
                            state_q <= StPlay;
                        end else if (frame_tick) begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
`ifdef LIVES_EN
                    StGameOver: begin
                        if (any_press) begin
                            lives     <= LIVES_LOAD;
                            game_over <= 1'b0;
                            state_q   <= StPlay;
                        end
                    end
`endif
                    default: state_q <= StPlay;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frog_controller.sv
// Bench for frog_controller: directed scenarios plus random stimulus, all checked
// every cycle against a rule-level model of frog position, level, cooldown and hits.
module tb_frog_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       collision = 1'b0;
    logic [9:0] frog_x, frog_y;
    logic [3:0] current_level;
    logic       level_up;
`ifdef LIVES_EN
    logic [1:0] lives;
    logic       game_over;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Model state: plain integers, counters hold the frames still to wait.
    int         mx, my, mlvl, mlu, mcool, mhit, mlives;
    bit         mlvlp, mgo;
    logic [3:0] mprev;

    frog_controller dut (
        .clk           (clk),
        .reset         (reset),
        .frame_tick    (frame_tick),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .collision     (collision),
        .frog_x        (frog_x),
        .frog_y        (frog_y),
        .current_level (current_level),
        .level_up      (level_up)
`ifdef LIVES_EN
        ,
        .lives         (lives),
        .game_over     (game_over)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mx = 304; my = 448; mlvl = 1; mlu = 0; mcool = 0; mhit = 0;
        mlvlp = 1'b0; mgo = 1'b0; mprev = 4'b0; mlives = 3;
    endtask

    task automatic model_step(input logic rst, input logic [3:0] b, input logic ft,
                              input logic col);
        logic [3:0] press;
        if (rst) begin
            model_reset();
            return;
        end
        press = b & ~mprev;
        mprev = b;
        mlu = 0;
        if (mlvlp) begin
            mlvl = (mlvl + 1 > 8) ? 8 : mlvl + 1;
            mlu = 1; mx = 304; my = 448; mlvlp = 1'b0; mcool = 4;
        end else if (mgo) begin
            if (press != 0) begin mlives = 3; mgo = 1'b0; end
        end else if (mhit > 0) begin
            if (ft) begin
                mhit--;
                if (mhit == 0) begin mx = 304; my = 448; end
            end
        end else if (ft && col) begin
            mcool = 0;
`ifdef LIVES_EN
            if (mlives == 1) begin
                mlives = 0; mgo = 1'b1; mx = 304; my = 448; mlvl = 1;
            end else begin
                mlives--; mhit = 30;
            end
`else
            mhit = 30;
`endif
        end else if (mcool > 0) begin
            if (ft) mcool--;
        end else if (press != 0) begin
            if (press[3])      my = (my - 32 < 0) ? 0 : my - 32;
            else if (press[2]) my = (my + 32 > 448) ? 448 : my + 32;
            else if (press[1]) mx = (mx - 32 < 0) ? 0 : mx - 32;
            else               mx = (mx + 32 > 608) ? 608 : mx + 32;
            if (my == 0) mlvlp = 1'b1;
            else mcool = 4;
        end
    endtask

    task automatic cycle(input logic [3:0] b, input logic ft, input logic col);
        {btn_up, btn_down, btn_left, btn_right} = b;
        frame_tick = ft;
        collision  = col;
        @(posedge clk);
        model_step(reset, b, ft, col);
        #1;
        check("frog_x", 32'(frog_x), 32'(mx));
        check("frog_y", 32'(frog_y), 32'(my));
        check("level", 32'(current_level), 32'(mlvl));
        check("level_up", 32'(level_up), 32'(mlu));
`ifdef LIVES_EN
        check("lives", 32'(lives), 32'(mlives));
        check("game_over", 32'(game_over), 32'(mgo));
`endif
    endtask

    task automatic hop(input logic [3:0] b);
        cycle(b, 1'b0, 1'b0);
        cycle(4'b0, 1'b0, 1'b0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(4'b0, 1'b1, 1'b0);
            cycle(4'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(4'b0, 1'b0, 1'b0);
        cycle(4'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    localparam logic [3:0] UP = 4'b1000, DN = 4'b0100, LF = 4'b0010, RT = 4'b0001;

    initial begin
        model_reset();
        // Reset values
        do_reset();
        check("rst_x", 32'(frog_x), 32'd304);
        check("rst_y", 32'(frog_y), 32'd448);
        check("rst_level", 32'(current_level), 32'd1);
        check("rst_level_up", 32'(level_up), 32'd0);

        // Hop, ignored hop in cooldown, hop after cooldown
        hop(UP);
        check("hop_up", 32'(frog_y), 32'd416);
        hop(UP);
        check("cooldown_block", 32'(frog_y), 32'd416);
        ticks(4);
        hop(UP);
        check("hop_after_cool", 32'(frog_y), 32'd384);
        cycle(UP, 1'b0, 1'b0);
        ticks(4);
        cycle(UP, 1'b0, 1'b0);
        check("held_no_repeat", 32'(frog_y), 32'd352);
        cycle(4'b0, 1'b0, 1'b0);
        ticks(4);
        hop(UP | RT);
        check("priority_up", 32'(frog_x), 32'd304);

        // Clamps
        do_reset();
        for (int i = 0; i < 10; i++) begin hop(LF); ticks(4); end
        check("clamp_left", 32'(frog_x), 32'd0);
        do_reset();
        for (int i = 0; i < 9; i++) begin hop(RT); ticks(4); end
        check("right_592", 32'(frog_x), 32'd592);
        hop(RT); ticks(4);
        check("clamp_right", 32'(frog_x), 32'd608);
        hop(DN); ticks(4);
        check("clamp_down", 32'(frog_y), 32'd448);

        // Level advance up to saturation
        do_reset();
        for (int i = 0; i < 14; i++) begin hop(UP); ticks(4); end
        check("level_2", 32'(current_level), 32'd2);
        check("respawn_y", 32'(frog_y), 32'd448);
        for (int l = 0; l < 7; l++) begin
            for (int i = 0; i < 14; i++) begin hop(UP); ticks(4); end
        end
        check("level_sat", 32'(current_level), 32'd8);

        // Collision beats a press, frozen for the hit frames
        hop(UP); ticks(4);
        cycle(RT, 1'b1, 1'b1);
        check("hit_no_move", 32'(frog_x), 32'd304);
        cycle(4'b0, 1'b0, 1'b0);
        for (int i = 0; i < 29; i++) begin hop(LF); ticks(1); end
        check("frozen", 32'(frog_y), 32'd416);
        ticks(1);
        check("hit_respawn_y", 32'(frog_y), 32'd448);
        check("hit_keep_level", 32'(current_level), 32'd8);
        cycle(4'b0, 1'b0, 1'b1);
        hop(RT);
        check("col_no_tick", 32'(frog_x), 32'd336);

`ifdef LIVES_EN
        do_reset();
        for (int h = 0; h < 3; h++) begin
            cycle(4'b0, 1'b1, 1'b1);
            cycle(4'b0, 1'b0, 1'b0);
            if (h < 2) ticks(30);
        end
        check("lives_0", 32'(lives), 32'd0);
        check("game_over", 32'(game_over), 32'd1);
        hop(UP);
        check("lives_reload", 32'(lives), 32'd3);
        check("go_no_move", 32'(frog_y), 32'd448);
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] b;
            for (int k = 0; k < 4; k++) b[k] = ($urandom_range(3) == 0);
            reset = ($urandom_range(499) == 0);
            cycle(b, $urandom_range(2) == 0, $urandom_range(3) == 0);
            reset = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
